// File: rtl/condicionador_botoes.sv
// Button conditioner for the LED-matrix puzzle: 2-FF sync, per-lane debounce,
// one-hot single-cycle press pulses and a saturating accepted-move counter.
module condicionador_botoes #(
    parameter int unsigned N_BOTOES        = 8,
    parameter int unsigned DEBOUNCE_CICLOS = 500000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_BOTOES-1:0] botoes_raw,
    input  logic                habilita,
    input  logic                limpa_jogadas,
    output logic [N_BOTOES-1:0] pulsos,
    output logic [N_BOTOES-1:0] pressionado,
    output logic                jogada,
    output logic [7:0]          num_jogadas
);

    localparam int unsigned      JOG_W   = 8;
    localparam logic [CNT_W-1:0] CNT_FIM = CNT_W'(DEBOUNCE_CICLOS - 1);
    localparam logic [JOG_W-1:0] JOG_MAX = '1;

    logic [N_BOTOES-1:0]            s1;
    logic [N_BOTOES-1:0]            s2;
    logic [N_BOTOES-1:0]            stable;
    logic [N_BOTOES-1:0]            stable_next;
    logic [N_BOTOES-1:0]            stable_q;
    logic [N_BOTOES-1:0][CNT_W-1:0] cnt;
    logic [N_BOTOES-1:0][CNT_W-1:0] cnt_next;
    logic [N_BOTOES-1:0]            rise;
    logic [N_BOTOES-1:0]            pulsos_next;

    // Two-flop synchronizer; only s2 feeds the debounce logic
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= botoes_raw;
            s2 <= s1;
        end
    end

    // A lane changes level only after DEBOUNCE_CICLOS consecutive differing samples
    always_comb begin
        stable_next = stable;
        cnt_next    = '0;
        for (int i = 0; i < int'(N_BOTOES); i++) begin
            if (s2[i] != stable[i]) begin
                if (cnt[i] == CNT_FIM) begin
                    stable_next[i] = s2[i];
                end else begin
                    cnt_next[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable   <= '0;
            stable_q <= '0;
            cnt      <= '0;
        end else begin
            stable   <= stable_next;
            stable_q <= stable;
            cnt      <= cnt_next;
        end
    end

    assign pressionado = stable;

    // Lowest-index rising lane wins; concurrent rises on other lanes are dropped
    assign rise        = stable & ~stable_q;
    assign pulsos_next = habilita ? (rise & (~rise + N_BOTOES'(1))) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pulsos      <= '0;
            jogada      <= 1'b0;
            num_jogadas <= '0;
        end else begin
            pulsos <= pulsos_next;
            jogada <= |pulsos_next;
            if (limpa_jogadas) begin
                num_jogadas <= '0;
            end else if ((|pulsos_next) && (num_jogadas != JOG_MAX)) begin
                num_jogadas <= num_jogadas + JOG_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_condicionador_botoes.sv
// Directed bench for condicionador_botoes with a short debounce window.
module tb_condicionador_botoes;

    localparam int unsigned N  = 8;
    localparam int unsigned D  = 4;
    localparam int unsigned CW = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] botoes_raw;
    logic         habilita;
    logic         limpa_jogadas;
    logic [N-1:0] pulsos;
    logic [N-1:0] pressionado;
    logic         jogada;
    logic [7:0]   num_jogadas;

    int errors = 0;
    int checks = 0;

    condicionador_botoes #(
        .N_BOTOES       (N),
        .DEBOUNCE_CICLOS(D),
        .CNT_W          (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .botoes_raw   (botoes_raw),
        .habilita     (habilita),
        .limpa_jogadas(limpa_jogadas),
        .pulsos       (pulsos),
        .pressionado  (pressionado),
        .jogada       (jogada),
        .num_jogadas  (num_jogadas)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n edges; pulse pattern pat expected only right after edge pulse_at
    task automatic run(input string tag, input int n, input int pulse_at, input logic [N-1:0] pat);
        logic [N-1:0] exp_p;
        for (int k = 1; k <= n; k++) begin
            tick();
            exp_p = (k == pulse_at) ? pat : '0;
            chk({tag, "_pulsos"}, 32'(pulsos), 32'(exp_p));
            chk({tag, "_jogada"}, 32'(jogada), 32'(|exp_p));
        end
    endtask

    initial begin
        rst           = 1'b1;
        botoes_raw    = '0;
        habilita      = 1'b0;
        limpa_jogadas = 1'b0;
        tick();
        tick();
        chk("rst_pulsos", 32'(pulsos), 32'h0);
        chk("rst_press", 32'(pressionado), 32'h0);
        chk("rst_jogada", 32'(jogada), 32'h0);
        chk("rst_num", 32'(num_jogadas), 32'h0);

        // Clean press on lane 3
        rst        = 1'b0;
        habilita   = 1'b1;
        botoes_raw = 8'h08;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("clean_pulsos", 32'(pulsos), (k == 7) ? 32'h08 : 32'h0);
            chk("clean_jogada", 32'(jogada), (k == 7) ? 32'h1 : 32'h0);
            chk("clean_press3", 32'(pressionado[3]), (k >= 6) ? 32'h1 : 32'h0);
        end
        chk("clean_num", 32'(num_jogadas), 32'd1);
        botoes_raw = '0;
        run("rel3", 10, 0, '0);
        chk("rel3_press", 32'(pressionado), 32'h0);

        // Bouncing lane 0, then a stable hold
        for (int k = 0; k < 10; k++) begin
            botoes_raw = (k % 2 == 0) ? 8'h01 : 8'h00;
            tick();
            chk("bounce_pulsos", 32'(pulsos), 32'h0);
            chk("bounce_press", 32'(pressionado), 32'h0);
        end
        botoes_raw = 8'h01;
        run("bounce_hold", 10, 7, 8'h01);
        chk("bounce_num", 32'(num_jogadas), 32'd2);
        botoes_raw = '0;
        run("rel0", 10, 0, '0);

        // Simultaneous rise on lanes 5 and 2
        botoes_raw = 8'h24;
        run("simul", 10, 7, 8'h04);
        chk("simul_press", 32'(pressionado), 32'h24);
        chk("simul_num", 32'(num_jogadas), 32'd3);
        botoes_raw = '0;
        run("rel52", 10, 0, '0);

        // Press while disabled, enable while held, then re-press
        habilita   = 1'b0;
        botoes_raw = 8'h02;
        run("dis_press", 10, 0, '0);
        chk("dis_press1", 32'(pressionado), 32'h02);
        habilita = 1'b1;
        run("dis_enable", 10, 0, '0);
        botoes_raw = '0;
        run("dis_release", 10, 0, '0);
        botoes_raw = 8'h02;
        run("dis_repress", 10, 7, 8'h02);
        chk("dis_num", 32'(num_jogadas), 32'd4);
        botoes_raw = '0;
        run("rel1", 10, 0, '0);

        // Saturation of the move counter
        for (int p = 0; p < 260; p++) begin
            botoes_raw = 8'h40;
            repeat (8) tick();
            botoes_raw = '0;
            repeat (8) tick();
        end
        chk("sat_num", 32'(num_jogadas), 32'd255);

        // Clear coincident with a pulse takes priority
        botoes_raw = 8'h40;
        repeat (6) tick();
        chk("clr_pre_pulsos", 32'(pulsos), 32'h0);
        limpa_jogadas = 1'b1;
        tick();
        chk("clr_pulsos", 32'(pulsos), 32'h40);
        chk("clr_num", 32'(num_jogadas), 32'd0);
        limpa_jogadas = 1'b0;
        tick();
        chk("clr_after_num", 32'(num_jogadas), 32'd0);
        chk("clr_after_pulsos", 32'(pulsos), 32'h0);
        botoes_raw = '0;
        run("rel6", 10, 0, '0);
        botoes_raw = 8'h80;
        run("lane7", 10, 7, 8'h80);
        chk("lane7_num", 32'(num_jogadas), 32'd1);
        botoes_raw = '0;
        run("rel7", 10, 0, '0);

        // Async reset in the middle of a debounce on lane 4
        botoes_raw = 8'h10;
        repeat (4) tick();
        rst = 1'b1;
        #1;
        chk("arst_num", 32'(num_jogadas), 32'd0);
        chk("arst_press", 32'(pressionado), 32'h0);
        chk("arst_pulsos", 32'(pulsos), 32'h0);
        tick();
        tick();
        rst = 1'b0;
        run("arst_hold", 10, 7, 8'h10);
        chk("arst_num_after", 32'(num_jogadas), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/condicionador_botoes.md
Name: condicionador_botoes

Overview:
Upstream input stage for the LED-matrix puzzle controller. Synchronizes the raw, bouncy, active-high player push-buttons and debounces them. Converts each press into a single-clock, one-hot toggle pulse that drives the controller's button inputs, so one press gives exactly one toggle. Also counts accepted moves for the game control unit.

Parameters:
N_BOTOES, 8, number of buttons/pulse lanes
DEBOUNCE_CICLOS, 500000, consecutive stable clk cycles required to accept a level change (10 ms at 50 MHz); legal range >= 2
CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CICLOS

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
botoes_raw  input  N_BOTOES  raw button levels, 1 = pressed, asynchronous to clk
habilita  input  1  from the control unit; 1 = presses are accepted (playing state)
limpa_jogadas  input  1  synchronous clear of the move counter
pulsos  output  N_BOTOES  registered one-hot (or zero) single-cycle press pulses to the matrix controller
pressionado  output  N_BOTOES  debounced stable level of each button
jogada  output  1  registered OR of pulsos; high in the same cycle as any pulse
num_jogadas  output  8  accepted-move counter, saturating

Behaviour:
- Reset (async, rst=1):
  - all synchronizer flops, stable levels, debounce counters, pulsos, jogada and num_jogadas go to 0 immediately.
  - Reset asserted mid-debounce discards the partial count.
  - A button held through reset release is treated as a fresh press once debounced.
- Synchronizer: per lane, 2-FF chain s1 -> s2. Only s2 is used downstream.
- Debounce: one counter per lane, independent.
  - s2 == stable: counter <= 0.
  - s2 != stable and counter < DEBOUNCE_CICLOS-1: counter increments.
  - s2 != stable and counter == DEBOUNCE_CICLOS-1: stable <= s2, counter <= 0.
  - Any bounce back to the stable value before acceptance clears the counter; pulses shorter than DEBOUNCE_CICLOS synchronized cycles are never accepted.
- pressionado = stable, for every lane.
- Press detect: rise = stable & ~stable_q, where stable_q is stable delayed 1 cycle.
- Pulse generation (registered):
  - If habilita=1 and rise != 0, pulsos <= the lowest-index set bit of rise only (one-hot); other simultaneous rises are dropped, not queued.
  - Otherwise pulsos <= 0.
  - pulsos is never high for two consecutive cycles on the same lane.
- Latency: a clean raw 0->1 change settled before edge 1 gives pulsos high in the cycle after edge DEBOUNCE_CICLOS+3, for exactly one cycle.
- Release (1->0) is debounced identically but produces no pulse.
- habilita=0: debouncing continues, pulses are suppressed. A rise while disabled is lost. Raising habilita while a button is held does not generate a pulse; a new release and press is required.
- jogada: registered, equal to |pulsos_next, so it is coincident with pulsos.
- num_jogadas:
  - limpa_jogadas=1: <= 0. Clear has priority over an increment in the same cycle.
  - Else if a pulse is generated: increment, saturating at 255.
- Held button: exactly one pulse per press regardless of hold length.

Test Plan:
- DEBOUNCE_CICLOS=4. Reset, habilita=1, drive botoes_raw[3]=1 cleanly before edge 1 -> pulsos=8'h08 and jogada=1 in the cycle after edge 7 only; num_jogadas=1; pressionado[3]=1 from edge 6 onward.
- Bounce: raw[0] toggles 1,0,1,0 every cycle for 10 cycles, then holds 1 -> no pulse during bouncing; exactly one pulsos=8'h01, 7 edges after the final stable 1.
- Simultaneous: raw[5] and raw[2] rise on the same edge -> single pulse 8'h04; lane 5 is dropped; num_jogadas increments by 1.
- habilita=0 during a press of raw[1], then habilita=1 while still held -> no pulse; release, then press again -> pulse 8'h02.
- Saturation/clear: 260 clean presses -> num_jogadas=255; assert limpa_jogadas in the same cycle as a pulse -> num_jogadas=0.
- Async reset mid-debounce (counter=2 on lane 4), release rst with raw[4] still 1 -> no early pulse; pulse 8'h10 exactly 7 edges after reset release.
